// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared helpers for the parameterised adder tree.
//   - clog2      : ceiling log2 as a constant function (clog2(1) = 0)
//   - count_at   : number of operands entering tree level 'lvl' for n channels
//   - DEF_LEVELS / DEF_SUM_W : derived widths for the default 4 x 4-bit config
//   Module instances derive their own LEVELS/SUM_W from their parameters using
//   the same functions; the DEF_* constants serve users of the default shape.
// -----------------------------------------------------------------------------
package adder_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Operands entering level 'lvl': ceil(n / 2^lvl). Each level halves the
    // count, rounding up because an odd leftover is passed through.
    function automatic int count_at(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    localparam int DEF_N_CH   = 4;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_LEVELS = clog2(DEF_N_CH);
    localparam int DEF_SUM_W  = DEF_WIDTH + DEF_LEVELS;

endpackage : adder_pkg

// File: rtl/adder_tree_level.sv
// -----------------------------------------------------------------------------
// adder_tree_level
//   One registered reduction level of the adder tree. Operand pairs
//   (2i, 2i+1) are added into a result one bit wider; an odd leftover operand
//   is zero-extended and registered unchanged.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears every register
//   valid_i  in   data_i carries a sample this cycle
//   tag_i    in   sideband bit travelling with the sample
//   data_i   in   IN_CNT operands of IN_W bits, operand k at [k*IN_W +: IN_W]
//   valid_o  out  registered valid
//   tag_o    out  registered tag (forced low on bubbles)
//   data_o   out  OUT_CNT results of IN_W+1 bits
// -----------------------------------------------------------------------------
module adder_tree_level #(
    parameter  int IN_CNT  = 4,
    parameter  int IN_W    = 4,
    localparam int OUT_CNT = (IN_CNT + 1) / 2,
    localparam int OUT_W   = IN_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic                     tag_i,
    input  logic [IN_CNT*IN_W-1:0]   data_i,
    output logic                     valid_o,
    output logic                     tag_o,
    output logic [OUT_CNT*OUT_W-1:0] data_o
);

    localparam int PAIRS = IN_CNT / 2;

    logic [OUT_CNT*OUT_W-1:0] data_d;
    logic [OUT_CNT*OUT_W-1:0] data_q;
    logic                     valid_q;
    logic                     tag_q;

    always_comb begin
        data_d = '0;
        for (int i = 0; i < PAIRS; i++) begin
            data_d[i*OUT_W +: OUT_W] = OUT_W'(data_i[(2*i)*IN_W +: IN_W])
                                     + OUT_W'(data_i[(2*i+1)*IN_W +: IN_W]);
        end
        // Odd operand count: the last operand has no partner and rides
        // through as if added to zero.
        if ((IN_CNT % 2) == 1) begin
            data_d[(OUT_CNT-1)*OUT_W +: OUT_W] = OUT_W'(data_i[(IN_CNT-1)*IN_W +: IN_W]);
        end
    end

    // Data only loads on valid so the output holds between samples and
    // whatever sits on data_i during a bubble never propagates.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            tag_q   <= valid_i & tag_i;
            if (valid_i) begin
                data_q <= data_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;

endmodule : adder_tree_level

// File: rtl/param_adder_tree.sv
// -----------------------------------------------------------------------------
// param_adder_tree
//   Streaming reduction: sums N_CH unsigned WIDTH-bit channels through a fully
//   pipelined binary adder tree (LEVELS registered levels, 1 sample/cycle),
//   then feeds an optional saturating running accumulator with a sticky
//   overflow flag. No backpressure.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data holds a sample this cycle
//   in_data    in   N_CH channels, channel k at [k*WIDTH +: WIDTH]
//   in_acc_en  in   add this sample into the accumulator (travels with it)
//   acc_clr    in   clear the accumulator stage this cycle
//   sum_valid  out  sum holds a fresh result (LEVELS cycles after in_valid)
//   sum        out  exact channel sum, SUM_W bits; holds while sum_valid=0
//   acc_valid  out  acc updated this cycle
//   acc        out  saturating running total, ACC_W bits
//   acc_ovf    out  sticky saturation flag since last clear/reset
// -----------------------------------------------------------------------------
module param_adder_tree
    import adder_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int WIDTH  = 4,
    parameter  int ACC_W  = 16,
    localparam int LEVELS = clog2(N_CH),
    localparam int SUM_W  = WIDTH + LEVELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  in_acc_en,
    input  logic                  acc_clr,
    output logic                  sum_valid,
    output logic [SUM_W-1:0]      sum,
    output logic                  acc_valid,
    output logic [ACC_W-1:0]      acc,
    output logic                  acc_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    // ------------------------------------------------------------------
    // Adder tree: level l reduces count_at(N_CH, l) operands of WIDTH+l
    // bits into half as many (rounded up) operands one bit wider.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_CNT  = count_at(N_CH, l);
        localparam int IN_W    = WIDTH + l;
        localparam int OUT_CNT = (IN_CNT + 1) / 2;

        logic [IN_CNT*IN_W-1:0]       lvl_in;
        logic                         lvl_vin;
        logic                         lvl_tin;
        logic [OUT_CNT*(IN_W+1)-1:0]  lvl_out;
        logic                         lvl_vout;
        logic                         lvl_tout;

        if (l == 0) begin : g_first
            assign lvl_in  = in_data;
            assign lvl_vin = in_valid;
            assign lvl_tin = in_acc_en;
        end else begin : g_next
            assign lvl_in  = g_lvl[l-1].lvl_out;
            assign lvl_vin = g_lvl[l-1].lvl_vout;
            assign lvl_tin = g_lvl[l-1].lvl_tout;
        end

        adder_tree_level #(
            .IN_CNT (IN_CNT),
            .IN_W   (IN_W)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .valid_i (lvl_vin),
            .tag_i   (lvl_tin),
            .data_i  (lvl_in),
            .valid_o (lvl_vout),
            .tag_o   (lvl_tout),
            .data_o  (lvl_out)
        );
    end

    // The last level has exactly one operand of SUM_W bits.
    logic             tree_valid;
    logic             tree_tag;
    logic [SUM_W-1:0] tree_sum;

    assign tree_valid = g_lvl[LEVELS-1].lvl_vout;
    assign tree_tag   = g_lvl[LEVELS-1].lvl_tout;
    assign tree_sum   = g_lvl[LEVELS-1].lvl_out;

    assign sum_valid = tree_valid;
    assign sum       = tree_sum;

    // ------------------------------------------------------------------
    // Accumulator stage, one register after the tree output.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_d,       acc_q;
    logic             acc_ovf_d,   acc_ovf_q;
    logic             acc_valid_d, acc_valid_q;
    logic [ACC_W:0]   acc_sum;
    logic             add_now;

    // One extra bit catches the carry out that signals saturation.
    assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(tree_sum);
    assign add_now = tree_valid & tree_tag;

    always_comb begin
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        acc_valid_d = 1'b0;
        if (acc_clr) begin
            // A clear coinciding with a tagged sum restarts the total from
            // that sum rather than dropping it.
            acc_ovf_d = 1'b0;
            if (add_now) begin
                acc_d       = ACC_W'(tree_sum);
                acc_valid_d = 1'b1;
            end else begin
                acc_d       = '0;
            end
        end else if (add_now) begin
            acc_valid_d = 1'b1;
            if (acc_sum[ACC_W]) begin
                acc_d     = ACC_MAX;
                acc_ovf_d = 1'b1;
            end else begin
                acc_d     = acc_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign acc       = acc_q;
    assign acc_ovf   = acc_ovf_q;
    assign acc_valid = acc_valid_q;

endmodule : param_adder_tree

// File: tb/tb_param_adder_tree.sv
// -----------------------------------------------------------------------------
// tb_param_adder_tree
//   Two instances: dut_a (4 x 4-bit, 8-bit accumulator) carries the directed
//   and randomized accumulator scenarios; dut_b (5 x 8-bit) covers the odd
//   channel count and three-level latency.
//   The reference model treats the tree as a pure delay line of exact sums
//   and applies the accumulator rules with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_param_adder_tree;

    localparam int NA = 4;
    localparam int WA = 4;
    localparam int LA = 2;
    localparam int SWA = 6;
    localparam int AWA = 8;
    localparam longint ACC_MAX_A = 255;

    localparam int NB = 5;
    localparam int WB = 8;
    localparam int LB = 3;
    localparam int SWB = 11;
    localparam int AWB = 16;

    logic clk;

    // dut_a signals
    logic                 rst_a, in_valid_a, in_acc_en_a, acc_clr_a;
    logic [NA*WA-1:0]     in_data_a;
    logic                 sum_valid_a, acc_valid_a, acc_ovf_a;
    logic [SWA-1:0]       sum_a;
    logic [AWA-1:0]       acc_a;

    // dut_b signals
    logic                 rst_b, in_valid_b, in_acc_en_b, acc_clr_b;
    logic [NB*WB-1:0]     in_data_b;
    logic                 sum_valid_b, acc_valid_b, acc_ovf_b;
    logic [SWB-1:0]       sum_b;
    logic [AWB-1:0]       acc_b;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    param_adder_tree #(.N_CH(NA), .WIDTH(WA), .ACC_W(AWA)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_acc_en (in_acc_en_a),
        .acc_clr   (acc_clr_a),
        .sum_valid (sum_valid_a),
        .sum       (sum_a),
        .acc_valid (acc_valid_a),
        .acc       (acc_a),
        .acc_ovf   (acc_ovf_a)
    );

    param_adder_tree #(.N_CH(NB), .WIDTH(WB), .ACC_W(AWB)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_acc_en (in_acc_en_b),
        .acc_clr   (acc_clr_b),
        .sum_valid (sum_valid_b),
        .sum       (sum_b),
        .acc_valid (acc_valid_b),
        .acc       (acc_b),
        .acc_ovf   (acc_ovf_b)
    );

    // ---------------- reference model for dut_a ----------------
    typedef struct {
        logic v;
        int   s;
        logic en;
    } ent_t;

    ent_t   pipe_q[$];
    logic   exp_sv, exp_en, exp_av, exp_ovf;
    int     exp_sum;
    longint exp_acc;

    task automatic reset_model_a();
        pipe_q.delete();
        for (int i = 0; i < LA - 1; i++) pipe_q.push_back('{1'b0, 0, 1'b0});
        exp_sv  = 1'b0;
        exp_en  = 1'b0;
        exp_sum = 0;
        exp_acc = 0;
        exp_av  = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // Driver: apply one cycle of inputs, step past the edge, advance model.
    task automatic cycle_a(input logic r, input logic v, input logic [NA*WA-1:0] d,
                           input logic en, input logic clr);
        int     s;
        longint t;
        ent_t   e;
        rst_a = r; in_valid_a = v; in_data_a = d; in_acc_en_a = en; acc_clr_a = clr;
        @(posedge clk);
        #1;
        if (r) begin
            reset_model_a();
        end else begin
            // Accumulator consumes the sum that was visible before this edge.
            if (clr) begin
                exp_ovf = 1'b0;
                if (exp_sv && exp_en) begin
                    exp_acc = exp_sum;
                    exp_av  = 1'b1;
                end else begin
                    exp_acc = 0;
                    exp_av  = 1'b0;
                end
            end else if (exp_sv && exp_en) begin
                t = exp_acc + exp_sum;
                if (t > ACC_MAX_A) begin
                    exp_acc = ACC_MAX_A;
                    exp_ovf = 1'b1;
                end else begin
                    exp_acc = t;
                end
                exp_av = 1'b1;
            end else begin
                exp_av = 1'b0;
            end
            s = 0;
            for (int k = 0; k < NA; k++) s += int'(d[k*WA +: WA]);
            pipe_q.push_back('{v, s, en});
            e = pipe_q.pop_front();
            exp_sv = e.v;
            exp_en = e.v && e.en;
            if (e.v) exp_sum = e.s;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle_a(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle_a(1'b1, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got=%0b exp=0", sum_valid_a); end
        checks++; if (sum_a !== '0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", sum_a); end
        checks++; if (acc_valid_a !== 1'b0) begin errors++; $display("FAIL reset_acc_valid got=%0b exp=0", acc_valid_a); end
        checks++; if (acc_a !== '0) begin errors++; $display("FAIL reset_acc got=%0d exp=0", acc_a); end
        checks++; if (acc_ovf_a !== 1'b0) begin errors++; $display("FAIL reset_acc_ovf got=%0b exp=0", acc_ovf_a); end
        cycle_a(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_single_max();
        cycle_a(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL single_early got=%0b exp=0", sum_valid_a); end
        cycle_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checks++; if (sum_valid_a !== 1'b1 || sum_a !== 6'd60) begin
            errors++; $display("FAIL single_sum got=%0b/%0d exp=1/60", sum_valid_a, sum_a); end
        cycle_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checks++; if (sum_valid_a !== 1'b0 || sum_a !== 6'd60) begin
            errors++; $display("FAIL single_after got=%0b/%0d exp=0/60", sum_valid_a, sum_a); end
    endtask

    task automatic test_back_to_back();
        logic [NA*WA-1:0] din [5];
        logic             vin [5];
        logic             ov  [5];
        int               os  [5];
        logic             xv  [5];
        int               xs  [5];
        din = '{16'h4321, 16'h0F0F, 16'hABCD, 16'h7777, 16'h0000};
        vin = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        xv  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        xs  = '{60, 10, 30, 30, 28};
        for (int i = 0; i < 5; i++) begin
            cycle_a(1'b0, vin[i], din[i], 1'b0, 1'b0);
            ov[i] = sum_valid_a;
            os[i] = int'(sum_a);
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ov[i] !== xv[i] || os[i] != xs[i]) begin
                errors++; $display("FAIL b2b_%0d got=%0b/%0d exp=%0b/%0d", i, ov[i], os[i], xv[i], xs[i]); end
        end
    endtask

    task automatic test_saturation();
        int acc_seen[$];
        int ovf_seen[$];
        int xa [6];
        int xo [6];
        xa = '{60, 120, 180, 240, 255, 255};
        xo = '{0, 0, 0, 0, 1, 1};
        cycle_a(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle_a(1'b0, i < 6, 16'hFFFF, 1'b1, 1'b0);
            if (acc_valid_a === 1'b1) begin
                acc_seen.push_back(int'(acc_a));
                ovf_seen.push_back(int'(acc_ovf_a));
            end
        end
        checks++; if (acc_seen.size() != 6) begin
            errors++; $display("FAIL sat_count got=%0d exp=6", acc_seen.size()); end
        for (int i = 0; i < 6 && i < acc_seen.size(); i++) begin
            checks++; if (acc_seen[i] != xa[i] || ovf_seen[i] != xo[i]) begin
                errors++; $display("FAIL sat_%0d got=%0d/%0d exp=%0d/%0d", i, acc_seen[i], ovf_seen[i], xa[i], xo[i]); end
        end
    endtask

    task automatic test_clr_priority();
        checks++; if (acc_a !== 8'd255 || acc_ovf_a !== 1'b1) begin
            errors++; $display("FAIL clr_pre got=%0d/%0b exp=255/1", acc_a, acc_ovf_a); end
        cycle_a(1'b0, 1'b1, 16'h4657, 1'b1, 1'b0);   // channels 7,5,6,4 -> 22
        cycle_a(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (sum_valid_a !== 1'b1 || sum_a !== 6'd22) begin
            errors++; $display("FAIL clr_sum got=%0b/%0d exp=1/22", sum_valid_a, sum_a); end
        cycle_a(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (acc_a !== 8'd22 || acc_ovf_a !== 1'b0 || acc_valid_a !== 1'b1) begin
            errors++; $display("FAIL clr_with_sum got=%0d/%0b/%0b exp=22/0/1", acc_a, acc_ovf_a, acc_valid_a); end
        cycle_a(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (acc_a !== 8'd0 || acc_ovf_a !== 1'b0 || acc_valid_a !== 1'b0) begin
            errors++; $display("FAIL clr_alone got=%0d/%0b/%0b exp=0/0/0", acc_a, acc_ovf_a, acc_valid_a); end
    endtask

    task automatic test_reset_in_flight();
        cycle_a(1'b0, 1'b1, 16'h1111, 1'b1, 1'b0);
        cycle_a(1'b0, 1'b1, 16'h2222, 1'b1, 1'b0);
        cycle_a(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle_a(1'b0, 1'b0, '0, 1'b0, 1'b0);
            checks++; if (sum_valid_a !== 1'b0 || acc_a !== '0 || acc_valid_a !== 1'b0) begin
                errors++; $display("FAIL flush_%0d got=%0b/%0d/%0b exp=0/0/0", i, sum_valid_a, acc_a, acc_valid_a); end
        end
        cycle_a(1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        checks++; if (sum_valid_a !== 1'b0) begin errors++; $display("FAIL post_rst_early got=%0b exp=0", sum_valid_a); end
        cycle_a(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (sum_valid_a !== 1'b1 || sum_a !== 6'd12) begin
            errors++; $display("FAIL post_rst_sum got=%0b/%0d exp=1/12", sum_valid_a, sum_a); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            cycle_a(1'b0, $urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            checks++;
            if (sum_valid_a !== exp_sv || int'(sum_a) != exp_sum || acc_valid_a !== exp_av
                || longint'(acc_a) != exp_acc || acc_ovf_a !== exp_ovf) begin
                errors++;
                if (bad < 10) $display("FAIL rand_%0d got sv=%0b s=%0d av=%0b a=%0d o=%0b exp sv=%0b s=%0d av=%0b a=%0d o=%0b",
                    i, sum_valid_a, sum_a, acc_valid_a, acc_a, acc_ovf_a, exp_sv, exp_sum, exp_av, exp_acc, exp_ovf);
                bad++;
            end
        end
    endtask

    task automatic test_wide_n5();
        logic [NB*WB-1:0] d;
        logic             dv [35];
        int               ds [35];
        logic             xv;
        int               xs = 0;
        rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; in_acc_en_b = 1'b0; acc_clr_b = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b0;
        checks++; if (sum_valid_b !== 1'b0 || sum_b !== '0) begin
            errors++; $display("FAIL n5_reset got=%0b/%0d exp=0/0", sum_valid_b, sum_b); end
        for (int j = 0; j < 35; j++) begin
            if (j == 0) begin
                d = '1; dv[j] = 1'b1;
            end else if (j < 3 || j > 32) begin
                d = {8'($urandom), 32'($urandom)}; dv[j] = 1'b0;
            end else begin
                d = {8'($urandom), 32'($urandom)}; dv[j] = $urandom_range(0, 3) != 0;
            end
            ds[j] = 0;
            for (int k = 0; k < NB; k++) ds[j] += int'(d[k*WB +: WB]);
            in_valid_b = dv[j]; in_data_b = d; in_acc_en_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            xv = (j >= LB - 1) ? dv[j-LB+1] : 1'b0;
            if (xv) xs = ds[j-LB+1];
            if (j == LB - 1) begin
                checks++; if (sum_valid_b !== 1'b1 || sum_b !== 11'd1275) begin
                    errors++; $display("FAIL n5_max got=%0b/%0d exp=1/1275", sum_valid_b, sum_b); end
            end
            checks++; if (sum_valid_b !== xv || int'(sum_b) != xs) begin
                errors++; $display("FAIL n5_stream_%0d got=%0b/%0d exp=%0b/%0d", j, sum_valid_b, sum_b, xv, xs); end
        end
        in_valid_b = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_a = 1'b1; in_valid_a = 1'b0; in_data_a = '0; in_acc_en_a = 1'b0; acc_clr_a = 1'b0;
        rst_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; in_acc_en_b = 1'b0; acc_clr_b = 1'b0;
        reset_model_a();
        #2;
        test_reset();
        test_single_max();
        test_back_to_back();
        test_saturation();
        test_clr_priority();
        test_reset_in_flight();
        test_random();
        test_wide_n5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_param_adder_tree
